// File: rtl/axis_frame_sink.sv
// AXI-Stream frame sink: captures one DEPTH-beat frame into RAM, checks tlast framing, registered read-back.
// Optional backpressure pattern enabled by defining AXIS_SINK_THROTTLE_EN.
module axis_frame_sink #(
    parameter int DEPTH           = 32768,
    parameter int AW              = 15,
    parameter int DW              = 32,
    parameter int THROTTLE_PERIOD = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tlast,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   beat_count,
    output logic          err_early_last,
    output logic          err_no_last
);

    if (DEPTH != (1 << AW)) begin : g_bad_depth
        $error("DEPTH must equal 2**AW");
    end
    if (THROTTLE_PERIOD < 2) begin : g_bad_period
        $error("THROTTLE_PERIOD must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t        state, state_next;
    logic [AW-1:0] wr_ptr;
    logic          ready;
    logic          accept;
    logic          at_end;
    logic          arm;
    logic [DW-1:0] mem [DEPTH];

`ifdef AXIS_SINK_THROTTLE_EN
    localparam int TW = $clog2(THROTTLE_PERIOD);
    logic [TW-1:0] thr_cnt;

    // Held at 0 outside RECV so every capture starts with the same ready pattern.
    always_ff @(posedge clk) begin
        if (!resetn || state != RECV)
            thr_cnt <= '0;
        else if (thr_cnt == TW'(THROTTLE_PERIOD - 1))
            thr_cnt <= '0;
        else
            thr_cnt <= thr_cnt + 1'b1;
    end

    assign ready = (state == RECV) && (thr_cnt != TW'(THROTTLE_PERIOD - 1));
`else
    assign ready = (state == RECV);
`endif

    assign s_tready = ready;
    assign accept   = s_tvalid & ready;
    assign at_end   = (wr_ptr == AW'(DEPTH - 1));
    assign arm      = start && (state == IDLE || state == DONE);
    assign busy     = (state == RECV);
    assign done     = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RECV;
            RECV:    if (accept && (s_tlast || at_end)) state_next = DONE;
            DONE:    if (start) state_next = RECV;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr         <= '0;
            beat_count     <= '0;
            err_early_last <= 1'b0;
            err_no_last    <= 1'b0;
        end else if (arm) begin
            wr_ptr         <= '0;
            beat_count     <= '0;
            err_early_last <= 1'b0;
            err_no_last    <= 1'b0;
        end else if (accept) begin
            // The final beat forces DONE, so the pointer parks instead of wrapping.
            if (!at_end) wr_ptr <= wr_ptr + 1'b1;
            beat_count <= beat_count + 1'b1;
            if (s_tlast && !at_end) err_early_last <= 1'b1;
            if (at_end && !s_tlast) err_no_last    <= 1'b1;
        end
    end

    // RAM is not reset; resetn gates the write so an aborted capture stops at once.
    always_ff @(posedge clk) begin
        if (resetn && accept) mem[wr_ptr] <= s_tdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) rd_data <= '0;
        else         rd_data <= mem[rd_addr];
    end

endmodule
